// File: rtl/data_memory_responder.sv
// data_memory_responder: word-addressed 16-bit memory that answers one
// controller request at a time. Each request gets a one-cycle
// complete_data pulse LATENCY cycles after it is accepted.
// Ports: clock/reset (async, active-high); D_macc request strobe with
// Data_rd/Data_addr/Data_din sampled on acceptance; Data_dout registered
// read data; complete_data one-cycle completion pulse.
module data_memory_responder #(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        D_macc,
  input  logic        Data_rd,
  input  logic [15:0] Data_addr,
  input  logic [15:0] Data_din,
  output logic [15:0] Data_dout,
  output logic        complete_data
);

  generate
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("data_memory_responder: LATENCY must be within 1..15");
    end
  endgenerate

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [3:0]             r_cnt;
  logic [3:0]             w_cnt_next;
  logic                   r_rd;
  logic [ADDR_BITS-1:0]   r_addr;
  logic [15:0]            r_din;
  logic [15:0]            r_dout;
  logic [15:0]            r_mem [0:DEPTH-1];
  logic                   w_accept;
  logic                   w_commit;
  logic                   w_unused_addr;

  // Address bits above ADDR_BITS-1 alias onto the same word.
  assign w_unused_addr = ^Data_addr;

  assign w_accept = (r_state == IDLE) && D_macc;
  // The last BUSY cycle ends on the commit edge, which is also the edge
  // that enters DONE.
  assign w_commit = (r_state == BUSY) && (r_cnt == 4'd0);

  // BUSY always lasts LATENCY cycles (at least one, even for LATENCY=1),
  // so the commit edge is exactly LATENCY edges after acceptance.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (D_macc) begin
          w_state_next = BUSY;
          w_cnt_next   = CNT_LOAD;
        end
      end
      BUSY: begin
        if (r_cnt == 4'd0) begin
          w_state_next = DONE;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      DONE: begin
        // A strobe still high after completion must not start a new request.
        w_state_next = D_macc ? HOLD : IDLE;
      end
      HOLD: begin
        if (!D_macc) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_rd    <= 1'b0;
      r_addr  <= '0;
      r_din   <= 16'h0000;
      r_dout  <= 16'h0000;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_rd   <= Data_rd;
        r_addr <= Data_addr[ADDR_BITS-1:0];
        r_din  <= Data_din;
      end
      if (w_commit && r_rd) begin
        r_dout <= r_mem[r_addr];
      end
    end
  end

  // Storage is never cleared. Reset forces IDLE immediately, so a write
  // whose commit edge has not arrived is simply never performed.
  always_ff @(posedge clock) begin
    if (w_commit && !r_rd) begin
      r_mem[r_addr] <= r_din;
    end
  end

  assign Data_dout     = r_dout;
  assign complete_data = (r_state == DONE);

endmodule
